multichannel_pwm: RTL and testbench
===================================

// Module: multichannel_pwm
// PURPOSE
//  N-channel PWM generator with a shared period counter and a per-channel mode:
//  classic edge-aligned PWM, or bit-reversed (dithered) PWM that spreads on-time across the period.
//  Duty updates are double-buffered: written any time, applied only at a period boundary (glitch-free).
//  Drives LED/motor/DAC-filter outputs on the board; one instance serves all channels of a subsystem.
// PARAMETERS
//  WIDTH       8   counter/level width; period = 2**WIDTH counter steps
//  CHANNELS    4   number of independent outputs
//  PRESCALE_W  8   width of the prescale input
//  CHAN_W      2   width of wr_chan; must be >= $clog2(CHANNELS), minimum 1
// PORTS
//  clock         in   1             system clock, all logic on posedge
//  reset         in   1             synchronous, active-high
//  enable        in   1             1 = run; 0 = hold counters and force outputs low
//  prescale      in   PRESCALE_W    counter advances once every prescale+1 clocks
//  wr_en         in   1             write strobe for the pending (shadow) registers
//  wr_chan       in   CHAN_W        target channel; values >= CHANNELS are ignored
//  wr_level      in   WIDTH         pending duty level
//  wr_mode       in   1             pending mode: 0 = edge-aligned, 1 = bit-reversed
//  out           out  CHANNELS      PWM outputs, registered
//  negout        out  CHANNELS      bitwise ~out at all times, including reset
//  period_start  out  1             one-clock pulse when the counter wraps to 0
// BEHAVIOUR
//  Reset: pre_cnt=0, counter=0, all pending/active level=0 and mode=0, out=0, negout=all 1, period_start=0.
//  Prescaler: when enable, pre_cnt increments; tick = (pre_cnt == prescale), and on tick pre_cnt <= 0.
//   prescale=0 -> tick every clock. If prescale changes to below pre_cnt, pre_cnt wraps naturally (mod 2**PRESCALE_W).
//  Counter: advances by 1 on tick, modulo 2**WIDTH. wrap = tick && counter == all-ones.
//  period_start: registered; 1 for exactly one clock after the cycle in which wrap occurs, else 0.
//  Shadow write: if wr_en && wr_chan < CHANNELS, pending[wr_chan] <= {wr_mode, wr_level}. Accepted regardless of enable.
//  Load: on wrap, every active[i] <= pending[i]. If a write coincides with wrap, active takes the OLD pending value;
//   the new value sits in pending until the next wrap.
//  Compare (per channel, registered, 1-clock latency from counter):
//   cmp = (mode==0) ? counter : bitrev(counter);   out[i] <= (active_level[i] > cmp).
//   level=0 -> out always 0; level=L -> exactly L high steps per period in both modes;
//   edge mode: high during counter 0..L-1.
//  enable=0: pre_cnt, counter frozen; out <= 0 next clock; period_start <= 0; pending writes still accepted.
//   enable re-asserted resumes from the frozen counter value (no restart).
//  Reset mid-period: everything returns to reset state on the next clock; pending writes are lost.
//  All arithmetic unsigned; no width extension of level/counter beyond WIDTH.
// STRUCTURE
//  Package pwm_pkg: PWM_MODE_EDGE=1'b0, PWM_MODE_BITREV=1'b1; function bitrev(WIDTH-bit) -> reversed vector.
//  Top: prescaler, counter, wrap/period_start, write decode.
//  Sub-module pwm_channel (generate-instantiated CHANNELS times): pending/active regs, mode mux, comparator, out flop.
// TESTING (WIDTH=8, CHANNELS=4, prescale=0 unless stated)
//  1. Reset held 3 clocks -> out=0000, negout=1111, period_start=0; release -> period_start first pulses 256 clocks later.
//  2. ch0 level=64 mode=0, after wrap -> out[0] high exactly 64 consecutive clocks per 256-clock period.
//  3. ch1 level=128 mode=1 -> out[1] toggles every clock (high when counter even); level=1 -> one high clock per period.
//  4. Mid-period write ch2 level=200 -> out[2] unchanged until next period_start; write on wrap cycle -> applied one period later.
//  5. prescale=3, ch0 level=64 mode=0 -> period 1024 clocks, out[0] high 256 clocks; wr_chan=4 write -> no channel changes.
//  6. enable=0 for 50 clocks mid-period -> out=0000, counter held; enable=1 -> period ends 50 clocks late; reset mid-run -> state 1.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multichannel PWM block.
//   PWM_MODE_EDGE / PWM_MODE_BITREV : per-channel compare mode encodings
//   bitrev()                         : reverses the low w bits of a vector (w <= BITREV_MAX_W)
package pwm_pkg;

    localparam logic PWM_MODE_EDGE   = 1'b0;
    localparam logic PWM_MODE_BITREV = 1'b1;

    localparam int unsigned BITREV_MAX_W = 32;

    // Reverse the full vector, then shift the interesting w bits down to the bottom.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                       input int unsigned             w);
        logic [BITREV_MAX_W-1:0] r;
        r = {<<{v}};
        return r >> (BITREV_MAX_W - w);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty/mode, compare against the shared counter, output flop.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   enable_i       0 forces the output low on the next clock
//   counter_i      shared period counter
//   wrap_i         period boundary strobe; copies pending -> active
//   wr_en_i        write strobe already decoded for this channel
//   wr_level_i     pending duty level
//   wr_mode_i      pending compare mode
//   out_o          registered PWM output
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] counter_i,
    input  logic             wrap_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_level_i,
    input  logic             wr_mode_i,
    output logic             out_o
);

    logic [WIDTH-1:0] pend_level_q;
    logic             pend_mode_q;
    logic [WIDTH-1:0] act_level_q;
    logic             act_mode_q;
    logic             out_q;
    logic             out_d;
    logic [WIDTH-1:0] cmp;

    // Bit-reversed compare spreads the high steps evenly across the period.
    always_comb begin
        cmp = counter_i;
        if (act_mode_q == PWM_MODE_BITREV) begin
            cmp = WIDTH'(bitrev(BITREV_MAX_W'(counter_i), WIDTH));
        end
        out_d = enable_i && (act_level_q > cmp);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_level_q <= '0;
            pend_mode_q  <= PWM_MODE_EDGE;
            act_level_q  <= '0;
            act_mode_q   <= PWM_MODE_EDGE;
            out_q        <= 1'b0;
        end else begin
            if (wr_en_i) begin
                pend_level_q <= wr_level_i;
                pend_mode_q  <= wr_mode_i;
            end
            // A write landing on the wrap cycle stays pending: active takes the old value.
            if (wrap_i) begin
                act_level_q <= pend_level_q;
                act_mode_q  <= pend_mode_q;
            end
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/multichannel_pwm.sv
// N-channel PWM generator with shared prescaler/period counter and per-channel
// edge-aligned or bit-reversed modes; duty updates take effect at period boundaries.
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   enable         1 = run; 0 = freeze counters, force outputs low
//   prescale       counter advances once every prescale+1 clocks
//   wr_en/wr_chan/wr_level/wr_mode  shadow register write (out-of-range channels ignored)
//   out            registered PWM outputs
//   negout         ~out
//   period_start   one-clock pulse after the counter wraps to 0
module multichannel_pwm
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned PRESCALE_W = 8,
    parameter int unsigned CHAN_W     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  wr_en,
    input  logic [CHAN_W-1:0]     wr_chan,
    input  logic [WIDTH-1:0]      wr_level,
    input  logic                  wr_mode,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   negout,
    output logic                  period_start
);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]      counter_q, counter_d;
    logic                  period_start_q;
    logic                  tick;
    logic                  wrap;
    logic [CHANNELS-1:0]   out_vec;

    // If prescale drops below pre_cnt, pre_cnt simply runs on and wraps mod 2**PRESCALE_W.
    always_comb begin
        tick      = enable && (pre_cnt_q == prescale);
        wrap      = tick && (counter_q == '1);
        pre_cnt_d = pre_cnt_q;
        counter_d = counter_q;
        if (enable) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
        end
        if (tick) begin
            counter_d = counter_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt_q      <= '0;
            counter_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            counter_q      <= counter_d;
            period_start_q <= wrap;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic wr_hit;
        // Channel indices >= CHANNELS never match, so such writes are dropped.
        assign wr_hit = wr_en && (wr_chan == CHAN_W'(i));

        pwm_channel #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk_i      (clock),
            .rst_i      (reset),
            .enable_i   (enable),
            .counter_i  (counter_q),
            .wrap_i     (wrap),
            .wr_en_i    (wr_hit),
            .wr_level_i (wr_level),
            .wr_mode_i  (wr_mode),
            .out_o      (out_vec[i])
        );
    end

    assign out          = out_vec;
    assign negout       = ~out_vec;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_multichannel_pwm.sv
module tb_multichannel_pwm;

    localparam int NCH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] prescale = '0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_chan = '0;
    logic [7:0] wr_level = '0;
    logic       wr_mode = 1'b0;
    logic [3:0] out;
    logic [3:0] negout;
    logic       period_start;

    multichannel_pwm #(
        .WIDTH      (8),
        .CHANNELS   (4),
        .PRESCALE_W (8),
        .CHAN_W     (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .prescale     (prescale),
        .wr_en        (wr_en),
        .wr_chan      (wr_chan),
        .wr_level     (wr_level),
        .wr_mode      (wr_mode),
        .out          (out),
        .negout       (negout),
        .period_start (period_start)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state (behavioural, updated once per rising edge)
    logic [7:0] m_pre, m_cnt;
    logic [7:0] m_plev [NCH];
    logic       m_pmode[NCH];
    logic [7:0] m_alev [NCH];
    logic       m_amode[NCH];
    logic [3:0] m_out;
    logic       m_ps;

    logic [8:0] sb_q[$];

    int meas_ones[NCH];
    int meas_rise[NCH];
    int meas_ps;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = v[7-b];
        return r;
    endfunction

    task automatic model_edge();
        logic       tk, wp;
        logic [3:0] nout;
        logic [7:0] c;
        if (reset) begin
            m_pre = '0; m_cnt = '0; m_out = '0; m_ps = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_plev[i] = '0; m_pmode[i] = 1'b0; m_alev[i] = '0; m_amode[i] = 1'b0;
            end
        end else begin
            tk = enable && (m_pre == prescale);
            wp = tk && (m_cnt == 8'hFF);
            for (int i = 0; i < NCH; i++) begin
                c = m_amode[i] ? rev8(m_cnt) : m_cnt;
                nout[i] = enable && (m_alev[i] > c);
            end
            m_ps = wp;
            if (enable) m_pre = tk ? 8'd0 : m_pre + 8'd1;
            if (tk) m_cnt = m_cnt + 8'd1;
            if (wp) begin
                for (int i = 0; i < NCH; i++) begin
                    m_alev[i] = m_plev[i]; m_amode[i] = m_pmode[i];
                end
            end
            if (wr_en && wr_chan < 3'(NCH)) begin
                m_plev[wr_chan[1:0]]  = wr_level;
                m_pmode[wr_chan[1:0]] = wr_mode;
            end
            m_out = nout;
        end
    endtask

    // One clock: predict, push, let the edge happen, pop and compare.
    task automatic step();
        logic [8:0] exp_v, obs_v;
        model_edge();
        sb_q.push_back({m_ps, ~m_out, m_out});
        @(posedge clock);
        #1;
        cyc++;
        exp_v = sb_q.pop_front();
        obs_v = {period_start, negout, out};
        n_cmp++;
        assert (obs_v === exp_v) else begin
            n_err++;
            $error("FAIL cycle%0d {ps,negout,out} observed=%b expected=%b", cyc, obs_v, exp_v);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_ps(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (period_start !== 1'b1 && n < budget);
        n_cmp++;
        assert (period_start === 1'b1) else begin
            n_err++;
            $error("FAIL wait_ps_timeout observed=%b expected=1 after %0d clocks", period_start, n);
        end
    endtask

    task automatic measure(input int n);
        logic [3:0] prev;
        prev = out;
        meas_ps = 0;
        for (int i = 0; i < NCH; i++) begin
            meas_ones[i] = 0; meas_rise[i] = 0;
        end
        for (int k = 0; k < n; k++) begin
            step();
            for (int i = 0; i < NCH; i++) begin
                if (out[i] === 1'b1) meas_ones[i]++;
                if (out[i] === 1'b1 && prev[i] === 1'b0) meas_rise[i]++;
            end
            prev = out;
            if (period_start === 1'b1) meas_ps++;
        end
    endtask

    task automatic write(input logic [2:0] ch, input logic [7:0] lvl, input logic md);
        wr_en = 1'b1; wr_chan = ch; wr_level = lvl; wr_mode = md;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int n;

        // 1. reset state and first period_start latency
        steps(3);
        check("reset_out", 32'(out), 0);
        check("reset_negout", 32'(negout), 32'hF);
        check("reset_ps", 32'(period_start), 0);
        reset = 1'b0;
        wait_ps(2000, n);
        check("first_ps_latency", n, 256);

        // 2. edge-aligned level 64 on ch0
        write(3'd0, 8'd64, 1'b0);
        wait_ps(2000, n);
        measure(256);
        check("ch0_edge_ones", meas_ones[0], 64);
        check("ch0_edge_runs", meas_rise[0], 1);
        check("ch0_period_ps", meas_ps, 1);

        // 3. bit-reversed 128 and 1 on ch1
        write(3'd1, 8'd128, 1'b1);
        wait_ps(2000, n);
        measure(256);
        check("ch1_rev128_ones", meas_ones[1], 128);
        check("ch1_rev128_toggles", meas_rise[1], 128);
        write(3'd1, 8'd1, 1'b1);
        wait_ps(2000, n);
        measure(256);
        check("ch1_rev1_ones", meas_ones[1], 1);

        // 4. mid-period write waits for the boundary; write on wrap is deferred a period
        steps(20);
        write(3'd2, 8'd200, 1'b0);
        measure(235);
        check("ch2_midwrite_held", meas_ones[2], 0);
        check("ch2_midwrite_ps", meas_ps, 1);
        measure(256);
        check("ch2_level200_ones", meas_ones[2], 200);
        while (m_cnt !== 8'hFF) step();
        write(3'd2, 8'd30, 1'b0);
        check("wrap_write_ps", 32'(period_start), 1);
        measure(256);
        check("ch2_old_level_kept", meas_ones[2], 200);
        measure(256);
        check("ch2_new_level_applied", meas_ones[2], 30);

        // 5. prescale=3 and an out-of-range channel write
        prescale = 8'd3;
        wait_ps(4000, n);
        measure(1024);
        check("pre3_period_ps", meas_ps, 1);
        check("pre3_last_is_ps", 32'(period_start), 1);
        check("pre3_ch0_ones", meas_ones[0], 256);
        write(3'd4, 8'd255, 1'b1);
        wait_ps(4000, n);
        measure(1024);
        check("badchan_ch0", meas_ones[0], 256);
        check("badchan_ch1", meas_ones[1], 4);
        check("badchan_ch2", meas_ones[2], 120);
        check("badchan_ch3", meas_ones[3], 0);

        // 6. enable=0 for 50 clocks stretches the period; pending writes still land
        steps(100);
        enable = 1'b0;
        steps(20);
        write(3'd3, 8'd10, 1'b0);
        steps(29);
        check("disabled_out", 32'(out), 0);
        check("disabled_ps", 32'(period_start), 0);
        enable = 1'b1;
        wait_ps(4000, n);
        check("stretched_period_rest", n, 924);
        measure(1024);
        check("ch3_written_while_off", meas_ones[3], 40);

        // Reset mid-run drops everything including pending writes
        prescale = 8'd0;
        steps(37);
        write(3'd1, 8'd99, 1'b0);
        reset = 1'b1;
        steps(3);
        check("rerst_out", 32'(out), 0);
        check("rerst_negout", 32'(negout), 32'hF);
        check("rerst_ps", 32'(period_start), 0);
        reset = 1'b0;
        wait_ps(2000, n);
        check("rerst_ps_latency", n, 256);
        measure(256);
        check("rerst_ch1_cleared", meas_ones[1], 0);
        check("rerst_ch0_cleared", meas_ones[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
